// File: rtl/sa_layer_sequencer.sv
// Multi-layer command sequencer: replays up to NUM_DESC preloaded layer descriptors
// into the engine's control registers, supervising each layer for error, timeout and abort.
module sa_layer_sequencer #(
    parameter int NUM_DESC = 8,
    parameter int IDX_W    = $clog2(NUM_DESC),
    parameter int TMO_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [1:0]       cfg_field,
    input  logic [31:0]      cfg_wdata,
    input  logic             i_run,
    input  logic [IDX_W:0]   i_desc_count,
    input  logic             i_abort,
    input  logic [TMO_W-1:0] i_timeout_cycles,
    output logic [31:0]      o_ctrl_reg0,
    output logic [31:0]      o_ctrl_reg1,
    output logic [31:0]      o_ctrl_reg2,
    output logic [31:0]      o_ctrl_reg3,
    input  logic             i_engine_done,
    input  logic             i_engine_error,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [1:0]       o_err_code,
    output logic [IDX_W-1:0] o_cur_desc
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_NEXT, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] ERR_ENGINE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    state_t state, state_next;

    logic [31:0]      rd_base_tab   [NUM_DESC];
    logic [31:0]      wr_base_tab   [NUM_DESC];
    logic [31:0]      num_trans_tab [NUM_DESC];

    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   count;
    logic [TMO_W-1:0] tmo_limit;
    logic [TMO_W-1:0] tmo_cnt;
    logic             done_q;
    logic             start_q;
    logic             done_edge;
    logic             timeout_hit;
    logic             last_desc;
    logic [1:0]       err_next;

    assign done_edge   = i_engine_done & ~done_q;
    assign timeout_hit = (tmo_limit != '0) && (tmo_cnt == tmo_limit);
    assign last_desc   = ({1'b0, idx} == count - (IDX_W+1)'(1));
    assign o_ctrl_reg0 = {31'b0, start_q};

    // NOTE: the descriptor table is a register file, not RAM, so it is cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DESC; i++) begin
                rd_base_tab[i]   <= '0;
                wr_base_tab[i]   <= '0;
                num_trans_tab[i] <= '0;
            end
        end else if (cfg_we && state == S_IDLE) begin
            case (cfg_field)
                2'd0:    rd_base_tab[cfg_addr]   <= cfg_wdata;
                2'd1:    wr_base_tab[cfg_addr]   <= cfg_wdata;
                2'd2:    num_trans_tab[cfg_addr] <= cfg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    always_comb begin
        state_next = state;
        err_next   = 2'd0;
        case (state)
            S_IDLE:  if (i_run) state_next = (i_desc_count == '0) ? S_DONE : S_LOAD;
            S_LOAD:  state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (i_abort) begin
                    err_next   = ERR_ABORT;
                    state_next = S_ERR;
                end else if (i_engine_error) begin
                    err_next   = ERR_ENGINE;
                    state_next = S_ERR;
                end else if (timeout_hit) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = S_ERR;
                end else if (done_edge) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT:  state_next = last_desc ? S_DONE : S_LOAD;
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            o_ctrl_reg1 <= '0;
            o_ctrl_reg2 <= '0;
            o_ctrl_reg3 <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_err_code  <= 2'd0;
            o_cur_desc  <= '0;
            idx         <= '0;
            count       <= '0;
            tmo_limit   <= '0;
            tmo_cnt     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q  <= i_engine_done;
            start_q <= (state_next == S_START);
            o_busy  <= (state_next inside {S_LOAD, S_START, S_WAIT, S_NEXT});
            o_done  <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (i_run) begin
                        count      <= i_desc_count;
                        tmo_limit  <= i_timeout_cycles;
                        o_error    <= 1'b0;
                        o_err_code <= 2'd0;
                        idx        <= '0;
                    end
                end
                S_LOAD: begin
                    o_ctrl_reg1 <= rd_base_tab[idx];
                    o_ctrl_reg2 <= wr_base_tab[idx];
                    o_ctrl_reg3 <= num_trans_tab[idx];
                    o_cur_desc  <= idx;
                end
                S_START: tmo_cnt <= '0;
                S_WAIT: begin
                    if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (state_next == S_ERR) begin
                        o_error    <= 1'b1;
                        o_err_code <= err_next;
                    end
                end
                S_NEXT: if (state_next == S_LOAD) idx <= idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_layer_sequencer.sv
// Directed bench for sa_layer_sequencer: multi-layer run, held done level, timeout,
// error/abort priority, config write lockout, empty run and mid-sequence reset.
module tb_sa_layer_sequencer;

    localparam int NUM_DESC = 8;
    localparam int IDX_W    = 3;
    localparam int TMO_W    = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [1:0]       cfg_field;
    logic [31:0]      cfg_wdata;
    logic             i_run;
    logic [IDX_W:0]   i_desc_count;
    logic             i_abort;
    logic [TMO_W-1:0] i_timeout_cycles;
    logic [31:0]      o_ctrl_reg0, o_ctrl_reg1, o_ctrl_reg2, o_ctrl_reg3;
    logic             i_engine_done;
    logic             i_engine_error;
    logic             o_busy, o_done, o_error;
    logic [1:0]       o_err_code;
    logic [IDX_W-1:0] o_cur_desc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_r [3] = '{32'h1000, 32'h2000, 32'h3000};
    logic [31:0] exp_w [3] = '{32'h8000, 32'h9000, 32'hA000};
    logic [31:0] exp_n [3] = '{32'd16,   32'd32,   32'd8};

    sa_layer_sequencer #(.NUM_DESC(NUM_DESC), .IDX_W(IDX_W), .TMO_W(TMO_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_field        (cfg_field),
        .cfg_wdata        (cfg_wdata),
        .i_run            (i_run),
        .i_desc_count     (i_desc_count),
        .i_abort          (i_abort),
        .i_timeout_cycles (i_timeout_cycles),
        .o_ctrl_reg0      (o_ctrl_reg0),
        .o_ctrl_reg1      (o_ctrl_reg1),
        .o_ctrl_reg2      (o_ctrl_reg2),
        .o_ctrl_reg3      (o_ctrl_reg3),
        .i_engine_done    (i_engine_done),
        .i_engine_error   (i_engine_error),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_error          (o_error),
        .o_err_code       (o_err_code),
        .o_cur_desc       (o_cur_desc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cfg_write(input int addr, input logic [1:0] field, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = IDX_W'(addr);
        cfg_field = field;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Issues a run and returns at the cycle the first start pulse should be visible.
    task automatic do_run(input int cnt, input int tmo);
        i_run            = 1'b1;
        i_desc_count     = (IDX_W+1)'(cnt);
        i_timeout_cycles = TMO_W'(tmo);
        tick();
        i_run = 1'b0;
        check("run_load_busy", o_busy, 1);
        check("run_err_clear", o_error, 0);
        check("run_no_start_in_load", o_ctrl_reg0, 0);
        tick();
        check("run_start_pulse", o_ctrl_reg0, 1);
    endtask

    // One-cycle done pulse from WAIT; returns in NEXT.
    task automatic end_layer();
        i_engine_done = 1'b1;
        tick();
        i_engine_done = 1'b0;
    endtask

    initial begin
        logic saw_start;
        logic saw_done;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_field = '0; cfg_wdata = '0;
        i_run = 1'b0; i_desc_count = '0; i_abort = 1'b0; i_timeout_cycles = '0;
        i_engine_done = 1'b0; i_engine_error = 1'b0;
        repeat (3) tick();
        check("rst_ctrl0", o_ctrl_reg0, 0);
        check("rst_ctrl1", o_ctrl_reg1, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_code", o_err_code, 0);
        check("rst_cur", o_cur_desc, 0);
        rst = 1'b0;
        tick();

        // Three-layer clean run
        for (int i = 0; i < 3; i++) begin
            cfg_write(i, 2'd0, exp_r[i]);
            cfg_write(i, 2'd1, exp_w[i]);
            cfg_write(i, 2'd2, exp_n[i]);
        end
        cfg_write(0, 2'd3, 32'hFFFF_FFFF);
        do_run(3, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_reg1_%0d", i), o_ctrl_reg1, exp_r[i]);
            check($sformatf("t1_reg2_%0d", i), o_ctrl_reg2, exp_w[i]);
            check($sformatf("t1_reg3_%0d", i), o_ctrl_reg3, exp_n[i]);
            check($sformatf("t1_cur_%0d", i), o_cur_desc, i);
            tick();
            check($sformatf("t1_pulse_end_%0d", i), o_ctrl_reg0, 0);
            repeat (18) tick();
            check($sformatf("t1_wait_busy_%0d", i), o_busy, 1);
            end_layer();
            check($sformatf("t1_next_busy_%0d", i), o_busy, 1);
            if (i < 2) begin
                tick();
                check($sformatf("t1_load_nostart_%0d", i), o_ctrl_reg0, 0);
                tick();
                check($sformatf("t1_start_d3_%0d", i), o_ctrl_reg0, 1);
            end
        end
        tick();
        check("t1_done_pulse", o_done, 1);
        check("t1_done_busy", o_busy, 0);
        check("t1_no_error", o_error, 0);
        check("t1_regs_hold", o_ctrl_reg1, 32'h3000);
        tick();
        check("t1_done_one_cycle", o_done, 0);

        // Done level held across layers completes only on a fresh rising edge
        do_run(2, 0);
        tick();
        i_engine_done = 1'b1;
        tick();
        tick();
        tick();
        check("t2_start_l1", o_ctrl_reg0, 1);
        check("t2_cur_l1", o_cur_desc, 1);
        repeat (5) tick();
        i_engine_done = 1'b0;
        check("t2_held_level_busy", o_busy, 1);
        repeat (15) tick();
        check("t2_still_busy", o_busy, 1);
        check("t2_still_l1", o_cur_desc, 1);
        check("t2_no_done_yet", o_done, 0);
        end_layer();
        tick();
        check("t2_done", o_done, 1);
        tick();

        // Timeout of 50 with a silent engine
        do_run(1, 50);
        repeat (51) tick();
        check("t3_wait50_busy", o_busy, 1);
        check("t3_wait50_noerr", o_error, 0);
        tick();
        check("t3_error", o_error, 1);
        check("t3_code", o_err_code, 2);
        check("t3_cur", o_cur_desc, 0);
        check("t3_busy", o_busy, 0);
        check("t3_no_done", o_done, 0);
        tick();
        check("t3_error_sticky", o_error, 1);
        check("t3_no_done_idle", o_done, 0);

        // Engine error coincident with done on descriptor 1
        do_run(3, 0);
        tick();
        end_layer();
        tick();
        tick();
        check("t4_start_l1", o_ctrl_reg0, 1);
        tick();
        i_engine_done = 1'b1;
        i_engine_error = 1'b1;
        tick();
        i_engine_done = 1'b0;
        i_engine_error = 1'b0;
        check("t4_error", o_error, 1);
        check("t4_code", o_err_code, 1);
        check("t4_cur", o_cur_desc, 1);
        check("t4_busy", o_busy, 0);
        saw_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            saw_start |= o_ctrl_reg0[0];
        end
        check("t4_no_more_start", saw_start, 0);

        // Abort held from run: ignored until WAIT, then wins over engine error
        i_abort = 1'b1;
        do_run(1, 0);
        i_engine_error = 1'b1;
        tick();
        check("t4_abort_ign_start", o_error, 0);
        check("t4_abort_wait_busy", o_busy, 1);
        tick();
        i_abort = 1'b0;
        i_engine_error = 1'b0;
        check("t4_abort_error", o_error, 1);
        check("t4_abort_code", o_err_code, 3);
        tick();

        // Config write during WAIT is dropped
        do_run(1, 0);
        tick();
        cfg_write(0, 2'd0, 32'h0000_DEAD);
        end_layer();
        tick();
        check("t5_done", o_done, 1);
        tick();
        do_run(1, 0);
        check("t5_reg1_intact", o_ctrl_reg1, 32'h1000);
        tick();
        end_layer();
        tick();
        check("t5_done2", o_done, 1);
        tick();

        // Empty run: done pulse without any start
        i_run = 1'b1;
        i_desc_count = '0;
        tick();
        i_run = 1'b0;
        saw_done  = o_done;
        saw_start = o_ctrl_reg0[0];
        for (int k = 0; k < 4; k++) begin
            tick();
            saw_done  |= o_done;
            saw_start |= o_ctrl_reg0[0];
        end
        check("t5_empty_done", saw_done, 1);
        check("t5_empty_no_start", saw_start, 0);
        check("t5_empty_no_error", o_error, 0);

        // Reset in the middle of layer 1
        do_run(2, 0);
        tick();
        end_layer();
        tick();
        tick();
        tick();
        check("t6_pre_cur", o_cur_desc, 1);
        check("t6_pre_reg1", o_ctrl_reg1, 32'h2000);
        rst = 1'b1;
        tick();
        check("t6_ctrl0", o_ctrl_reg0, 0);
        check("t6_ctrl1", o_ctrl_reg1, 0);
        check("t6_ctrl2", o_ctrl_reg2, 0);
        check("t6_ctrl3", o_ctrl_reg3, 0);
        check("t6_busy", o_busy, 0);
        check("t6_done", o_done, 0);
        check("t6_error", o_error, 0);
        check("t6_code", o_err_code, 0);
        check("t6_cur", o_cur_desc, 0);
        rst = 1'b0;
        tick();
        cfg_write(0, 2'd0, 32'h4000);
        cfg_write(0, 2'd1, 32'hB000);
        cfg_write(0, 2'd2, 32'd4);
        do_run(1, 0);
        check("t6_fresh_reg1", o_ctrl_reg1, 32'h4000);
        check("t6_fresh_reg2", o_ctrl_reg2, 32'hB000);
        check("t6_fresh_reg3", o_ctrl_reg3, 32'd4);
        tick();
        end_layer();
        tick();
        check("t6_fresh_done", o_done, 1);
        check("t6_fresh_noerr", o_error, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
